// File: rtl/pedidos_pkg.sv
// Shared types for the PoLift request intake path.
// Holds the intake FSM states and the request record layout.
package pedidos_pkg;

    localparam int ANDAR_W_PADRAO = 4;

    typedef enum logic [1:0] {
        DESLIGADO = 2'b00,
        ESPERA    = 2'b01,
        VALIDA    = 2'b10
    } estado_t;

    typedef struct packed {
        logic [ANDAR_W_PADRAO-1:0] origem;
        logic [ANDAR_W_PADRAO-1:0] destino;
    } pedido_t;

endpackage

// File: rtl/fifo_pedidos.sv
// Synchronous request FIFO with flush and an occupied-entry lookup.
// The lookup comparator exists only when PEDIDO_DEDUP_EN is defined.
module fifo_pedidos #(
    parameter int DATA_W       = 8,
    parameter int PROFUNDIDADE = 4,
    localparam int PTR_W       = $clog2(PROFUNDIDADE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] dado,
    input  logic [DATA_W-1:0] consulta,
    output logic [DATA_W-1:0] head,
    output logic              cheia,
    output logic              vazia,
    output logic [PTR_W:0]    contagem,
    output logic              repetido
);

    logic [DATA_W-1:0] mem [PROFUNDIDADE];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign vazia   = (contagem == '0);
    assign cheia   = (contagem == (PTR_W+1)'(PROFUNDIDADE));
    assign pop_ok  = pop & ~vazia;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign push_ok = push & (~cheia | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            contagem <= '0;
            for (int i = 0; i < PROFUNDIDADE; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            contagem <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= dado;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok) contagem <= contagem + 1'b1;
            else if (!push_ok && pop_ok) contagem <= contagem - 1'b1;
        end
    end

`ifdef PEDIDO_DEDUP_EN
    always_comb begin
        logic [PTR_W-1:0] idx;
        repetido = 1'b0;
        idx      = '0;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((32'(contagem) > i) && (mem[idx] == consulta)) repetido = 1'b1;
        end
    end
`else
    logic unused_consulta;
    assign unused_consulta = ^consulta;
    assign repetido        = 1'b0;
`endif

endmodule

// File: rtl/captura_pedidos.sv
// Request intake: synchronizer, capture/validate FSM and request FIFO.
// Optional PEDIDO_DEDUP_EN drops requests already waiting in the FIFO.
module captura_pedidos
    import pedidos_pkg::*;
#(
    parameter int ANDAR_W      = ANDAR_W_PADRAO,
    parameter int NUM_ANDARES  = 16,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic [ANDAR_W-1:0]              origem,
    input  logic [ANDAR_W-1:0]              destino,
    input  logic                            novaEntrada,
    output logic                            pedido_valido,
    output logic [ANDAR_W-1:0]              pedido_origem,
    output logic [ANDAR_W-1:0]              pedido_destino,
    input  logic                            pedido_aceito,
    output logic                            fila_cheia,
    output logic                            fila_vazia,
    output logic [$clog2(PROFUNDIDADE):0]   contagem,
    output logic                            erro_pedido,
    output logic                            descartado,
    output logic                            pedido_duplicado,
    output logic [1:0]                      db_estado
);

    logic s1, s2, s3;
    logic borda;
    estado_t estado, proximo;
    logic [ANDAR_W-1:0] orig_q, dest_q;
    logic [2*ANDAR_W-1:0] head;
    logic invalido, repetido, pop;
    logic captura, escreve;
    logic erro_d, desc_d, dup_d;

    assign borda    = s2 & ~s3;
    assign invalido = (orig_q == dest_q)
                    || (32'(orig_q) >= NUM_ANDARES)
                    || (32'(dest_q) >= NUM_ANDARES);
    // Dropping iniciar flushes the FIFO, so the pop must not also count
    assign pop            = pedido_valido & pedido_aceito & iniciar;
    assign pedido_valido  = ~fila_vazia;
    assign pedido_origem  = head[2*ANDAR_W-1:ANDAR_W];
    assign pedido_destino = head[ANDAR_W-1:0];
    assign db_estado      = estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1               <= 1'b0;
            s2               <= 1'b0;
            s3               <= 1'b0;
            estado           <= DESLIGADO;
            orig_q           <= '0;
            dest_q           <= '0;
            erro_pedido      <= 1'b0;
            descartado       <= 1'b0;
            pedido_duplicado <= 1'b0;
        end else begin
            s1               <= novaEntrada;
            s2               <= s1;
            s3               <= s2;
            estado           <= proximo;
            erro_pedido      <= erro_d;
            descartado       <= desc_d;
            pedido_duplicado <= dup_d;
            if (captura) begin
                orig_q <= origem;
                dest_q <= destino;
            end
        end
    end

    always_comb begin
        proximo = estado;
        captura = 1'b0;
        escreve = 1'b0;
        erro_d  = 1'b0;
        desc_d  = 1'b0;
        dup_d   = 1'b0;
        if (!iniciar) begin
            proximo = DESLIGADO;
        end else begin
            case (estado)
                DESLIGADO: proximo = ESPERA;
                ESPERA: begin
                    if (borda) begin
                        captura = 1'b1;
                        proximo = VALIDA;
                    end
                end
                VALIDA: begin
                    proximo = ESPERA;
                    if (invalido) erro_d = 1'b1;
                    else if (repetido) dup_d = 1'b1;
                    else if (fila_cheia && !pop) desc_d = 1'b1;
                    else escreve = 1'b1;
                end
                default: proximo = DESLIGADO;
            endcase
        end
    end

    fifo_pedidos #(
        .DATA_W       (2*ANDAR_W),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (~iniciar),
        .push     (escreve),
        .pop      (pop),
        .dado     ({orig_q, dest_q}),
        .consulta ({orig_q, dest_q}),
        .head     (head),
        .cheia    (fila_cheia),
        .vazia    (fila_vazia),
        .contagem (contagem),
        .repetido (repetido)
    );

endmodule
